change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter DOLLAR_CAP, default 15, dollar-coin inventory after reset or reload (legal range 1..15).
REQ-002 SHALL have parameter QUARTER_CAP, default 63, quarter-coin inventory after reset or reload (legal range 1..63).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255, maximum number of cycles an eject may wait for coin_ack (legal range 1..255).
REQ-004 SHALL use clock clk; reset is reset, synchronous, active-high.
REQ-005 SHALL have the following ports:
- clk, input, 1 bit, clock.
- reset, input, 1 bit, synchronous active-high reset.
- start, input, 1 bit, request a payout; sampled only in IDLE.
- amount, input, 12 bits, change to pay in cents; latched when start is accepted.
- coin_ack, input, 1 bit, hopper confirms that the requested coin was released.
- load_dollar, input, 1 bit, refill dollar inventory to DOLLAR_CAP; honoured only in IDLE.
- load_quarter, input, 1 bit, refill quarter inventory to QUARTER_CAP; honoured only in IDLE.
- busy, output, 1 bit, high in every state except IDLE.
- eject_dollar, output, 1 bit, request release of one dollar coin.
- eject_quarter, output, 1 bit, request release of one quarter.
- done, output, 1 bit, one-cycle pulse on normal completion.
- error, output, 1 bit, one-cycle pulse on short inventory or timeout.
- remaining, output, 12 bits, cents still unpaid.
- dollars_left, output, 4 bits, dollar inventory.
- quarters_left, output, 6 bits, quarter inventory.

Function
REQ-006 SHALL implement the FSM states IDLE, SELECT, EJECT_D, EJECT_Q, DONE and ERROR.
REQ-007 In IDLE with start=1, SHALL latch remaining<=amount and go to SELECT on the next cycle; busy SHALL rise in that same cycle.
REQ-008 SELECT SHALL choose the next state in this priority order:
- remaining>=100 and dollars_left>0 -> EJECT_D;
- else remaining>=25 and quarters_left>0 -> EJECT_Q;
- else remaining<25 -> DONE;
- else -> ERROR.
REQ-009 eject_dollar SHALL be 1 exactly while in EJECT_D, and eject_quarter SHALL be 1 exactly while in EJECT_Q; both outputs are decoded from registered state.
REQ-010 In EJECT_x with coin_ack=1, on the same edge SHALL decrement the matching inventory by 1, subtract 100 or 25 from remaining, clear the timeout counter, and return to SELECT.
REQ-011 Each coin SHALL take at least 2 cycles (EJECT plus SELECT), so eject is low for at least one cycle between consecutive coins.
REQ-012 SHALL count cycles spent in EJECT_x without coin_ack; when the count reaches ACK_TIMEOUT it SHALL go to ERROR with no decrement of inventory or remaining.
REQ-013 coin_ack outside EJECT_D and EJECT_Q SHALL be ignored.
REQ-014 DONE and ERROR SHALL each last one cycle, pulsing done or error respectively, then return to IDLE.
REQ-015 remaining SHALL hold its value after DONE or ERROR until the next accepted start: it is the residue below 25 after DONE, or the unpaid amount after ERROR.
REQ-016 start while busy=1 SHALL be ignored; amount is not re-latched.
REQ-017 Loads in IDLE SHALL take effect on the next edge; load_dollar and load_quarter together SHALL refill both inventories; loads while busy SHALL be ignored.
REQ-018 amount=0 SHALL go IDLE->SELECT->DONE, with done high in the 3rd cycle after start is sampled and no eject issued.
REQ-019 Inventory counters SHALL never wrap, since the zero-inventory checks in SELECT prevent any decrement below 0.

Reset
REQ-020 reset SHALL force state=IDLE, busy=0, eject_dollar=0, eject_quarter=0, done=0, error=0, remaining=0, dollars_left=DOLLAR_CAP, quarters_left=QUARTER_CAP, and timeout counter=0.
REQ-021 reset SHALL override all other inputs, including during EJECT_x; any coin_ack in a reset cycle SHALL have no effect.

Verification
REQ-022 After reset, start with amount=250 and coin_ack asserted one cycle after each eject SHALL produce eject order D, D, Q, Q, then a done pulse, with remaining=0, dollars_left=13 and quarters_left=61.
REQ-023 amount=130 SHALL produce one D and one Q, then done, with remaining=5.
REQ-024 After 15 dollar payouts (dollars_left=0), amount=100 SHALL produce four Q ejects, then done, with dollars_left=0; load_dollar in IDLE SHALL then restore dollars_left=15.
REQ-025 amount=75 with coin_ack held low SHALL keep eject_quarter high for 255 cycles, then pulse error, with remaining=75 and quarters_left unchanged.
REQ-026 reset asserted while in EJECT_D SHALL bring eject_dollar=0 and busy=0 on the next cycle, with inventories back at their caps.
REQ-027 start pulsed again mid-payout with a different amount SHALL be ignored, and the original payout SHALL complete unchanged.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays an amount in cents greedily with dollars then quarters,
// handshaking each coin with the hopper and tracking both coin inventories.
`timescale 1ns/1ps
module change_dispenser #(
    parameter int DOLLAR_CAP  = 15,
    parameter int QUARTER_CAP = 63,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] amount,
    input  logic        coin_ack,
    input  logic        load_dollar,
    input  logic        load_quarter,
    output logic        busy,
    output logic        eject_dollar,
    output logic        eject_quarter,
    output logic        done,
    output logic        error,
    output logic [11:0] remaining,
    output logic [3:0]  dollars_left,
    output logic [5:0]  quarters_left
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        EJECT_D = 3'd2,
        EJECT_Q = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } state_t;

    localparam logic [3:0] DOLLAR_INIT  = 4'(DOLLAR_CAP);
    localparam logic [5:0] QUARTER_INIT = 6'(QUARTER_CAP);
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [11:0] remaining_q, remaining_d;
    logic [3:0]  dollars_q, dollars_d;
    logic [5:0]  quarters_q, quarters_d;
    logic [7:0]  timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dollars_d   = dollars_q;
        quarters_d  = quarters_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    state_d     = SELECT;
                end
                if (load_dollar) begin
                    dollars_d = DOLLAR_INIT;
                end
                if (load_quarter) begin
                    quarters_d = QUARTER_INIT;
                end
            end
            SELECT: begin
                if (remaining_q >= 12'd100 && dollars_q != 4'd0) begin
                    state_d = EJECT_D;
                end else if (remaining_q >= 12'd25 && quarters_q != 6'd0) begin
                    state_d = EJECT_Q;
                end else if (remaining_q < 12'd25) begin
                    state_d = DONE;
                end else begin
                    state_d = ERROR;
                end
            end
            EJECT_D, EJECT_Q: begin
                if (coin_ack) begin
                    timeout_d = 8'd0;
                    state_d   = SELECT;
                    if (state_q == EJECT_D) begin
                        dollars_d   = dollars_q - 4'd1;
                        remaining_d = remaining_q - 12'd100;
                    end else begin
                        quarters_d  = quarters_q - 6'd1;
                        remaining_d = remaining_q - 12'd25;
                    end
                end else if (timeout_q == TIMEOUT_LAST) begin
                    // Hopper never answered: abandon the payout, nothing was released.
                    timeout_d = 8'd0;
                    state_d   = ERROR;
                end else begin
                    timeout_d = timeout_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= 12'd0;
            dollars_q   <= DOLLAR_INIT;
            quarters_q  <= QUARTER_INIT;
            timeout_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dollars_q   <= dollars_d;
            quarters_q  <= quarters_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign eject_dollar  = (state_q == EJECT_D);
    assign eject_quarter = (state_q == EJECT_Q);
    assign done          = (state_q == DONE);
    assign error         = (state_q == ERROR);
    assign remaining     = remaining_q;
    assign dollars_left  = dollars_q;
    assign quarters_left = quarters_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues the expected
// coin/termination events, a negedge monitor pops and compares them as they appear.
`timescale 1ns/1ps
module tb_change_dispenser;

    localparam int K_D = 0, K_Q = 1, K_DONE = 2, K_ERR = 3;

    typedef struct {
        int kind;
        int rem;
        int dl;
        int ql;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, coin_ack, load_dollar, load_quarter;
    logic [11:0] amount;
    logic        busy, eject_dollar, eject_quarter, done, error;
    logic [11:0] remaining;
    logic [3:0]  dollars_left;
    logic [5:0]  quarters_left;

    logic hop_ack   = 1'b0;
    logic force_ack = 1'b0;
    logic ack_en    = 1'b1;
    int   ack_delay = 1;
    int   hop_wait  = 0;

    exp_t sb[$];
    int   m_dl = 15, m_ql = 63;
    int   n_compared = 0, n_mismatched = 0;
    logic prev_d = 1'b0, prev_q = 1'b0;
    int   q_run = 0, q_run_last = 0;

    assign coin_ack = hop_ack | force_ack;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount), .coin_ack(coin_ack),
        .load_dollar(load_dollar), .load_quarter(load_quarter), .busy(busy),
        .eject_dollar(eject_dollar), .eject_quarter(eject_quarter), .done(done),
        .error(error), .remaining(remaining), .dollars_left(dollars_left),
        .quarters_left(quarters_left)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Greedy reference: the expected coin sequence and final state for one payout.
    task automatic plan(input int amt);
        int rem = amt;
        forever begin
            if (rem >= 100 && m_dl > 0) begin
                sb.push_back('{K_D, 0, 0, 0}); m_dl--; rem -= 100;
            end else if (rem >= 25 && m_ql > 0) begin
                sb.push_back('{K_Q, 0, 0, 0}); m_ql--; rem -= 25;
            end else begin
                sb.push_back('{(rem < 25) ? K_DONE : K_ERR, rem, m_dl, m_ql});
                break;
            end
        end
    endtask

    task automatic pop_event(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", kind, -1);
        end else begin
            e = sb.pop_front();
            $display("event kind=%0d rem=%0d dl=%0d ql=%0d", kind, remaining, dollars_left, quarters_left);
            check("event_kind", kind, e.kind);
            if (kind >= K_DONE) begin
                check("end_remaining", int'(remaining), e.rem);
                check("end_dollars", int'(dollars_left), e.dl);
                check("end_quarters", int'(quarters_left), e.ql);
            end
        end
    endtask

    // Hopper model: acknowledges each eject ack_delay cycles after it appears.
    always @(negedge clk) begin
        if (ack_en && (eject_dollar || eject_quarter)) begin
            if (hop_wait == ack_delay) hop_ack = 1'b1;
            else hop_wait++;
        end else begin
            hop_ack  = 1'b0;
            hop_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (eject_dollar && !prev_d) pop_event(K_D);
            if (eject_quarter && !prev_q) pop_event(K_Q);
            if (done) pop_event(K_DONE);
            if (error) pop_event(K_ERR);
            if (eject_dollar && eject_quarter) check("both_ejects", 1, 0);
        end
        if (eject_quarter) q_run++;
        else begin
            if (prev_q) q_run_last = q_run;
            q_run = 0;
        end
        prev_d = eject_dollar;
        prev_q = eject_quarter;
    end

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic pulse_start(input int amt);
        start  = 1'b1;
        amount = 12'(amt);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic payout(input int amt);
        plan(amt);
        pulse_start(amt);
        wait_idle(2000);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; amount = 12'd0;
        load_dollar = 1'b0; load_quarter = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_eject_d", eject_dollar, 0);
        check("rst_eject_q", eject_quarter, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_remaining", remaining, 0);
        check("rst_dollars", dollars_left, 15);
        check("rst_quarters", quarters_left, 63);

        payout(250);
        payout(130);
        repeat (3) @(negedge clk);
        check("remaining_hold", remaining, 5);

        // Zero amount: SELECT then DONE in the third cycle counting the start cycle.
        plan(0);
        start = 1'b1; amount = 12'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_busy_c2", busy, 1);
        check("zero_done_c2", done, 0);
        @(negedge clk);
        check("zero_done_c3", done, 1);
        wait_idle(20);

        payout(1200);
        check("dollars_exhausted", dollars_left, 0);
        payout(100);
        check("dollars_still_zero", dollars_left, 0);
        load_dollar = 1'b1;
        @(negedge clk);
        load_dollar = 1'b0;
        m_dl = 15;
        check("load_dollar", dollars_left, 15);
        check("load_dollar_q_kept", quarters_left, m_ql);

        // Hopper silent: eject_quarter stays up for the full timeout.
        ack_en = 1'b0;
        sb.push_back('{K_Q, 0, 0, 0});
        sb.push_back('{K_ERR, 75, m_dl, m_ql});
        pulse_start(75);
        wait_idle(400);
        check("timeout_run", q_run_last, 255);
        ack_en = 1'b1;

        // Second start with a different amount mid-payout must be ignored.
        plan(250);
        pulse_start(250);
        repeat (3) @(negedge clk);
        pulse_start(100);
        wait_idle(200);

        // Short inventory; loads issued while busy must not refill.
        plan(4095);
        pulse_start(4095);
        repeat (10) @(negedge clk);
        load_dollar = 1'b1; load_quarter = 1'b1;
        @(negedge clk);
        load_dollar = 1'b0; load_quarter = 1'b0;
        wait_idle(2000);
        load_dollar = 1'b1; load_quarter = 1'b1;
        @(negedge clk);
        load_dollar = 1'b0; load_quarter = 1'b0;
        m_dl = 15; m_ql = 63;
        check("load_both_d", dollars_left, 15);
        check("load_both_q", quarters_left, 63);
        check("err_remaining_hold", remaining, 1445);

        // Reset in EJECT_D with coin_ack high must abort cleanly.
        ack_en = 1'b0;
        sb.push_back('{K_D, 0, 0, 0});
        pulse_start(100);
        for (int i = 0; i < 10 && !eject_dollar; i++) @(negedge clk);
        check("reach_eject_d", eject_dollar, 1);
        reset = 1'b1; force_ack = 1'b1;
        @(negedge clk);
        check("mid_rst_eject_d", eject_dollar, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dollars", dollars_left, 15);
        check("mid_rst_quarters", quarters_left, 63);
        reset = 1'b0; force_ack = 1'b0;
        sb.delete();
        m_dl = 15; m_ql = 63;
        ack_en = 1'b1;
        payout(130);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
